// File: rtl/tb_column_reader_if.sv
// Port bundle for the column reader: the row-fetch stream in and the column stream out.
// The slave modport is the reader itself; the master modport is whoever feeds and drains it.
interface tb_column_reader_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int TB_HEIGHT   = 2
);
  localparam int COL_W = $clog2(FETCH_WIDTH);

  logic                              in_valid;
  logic [FETCH_WIDTH*WORD_WIDTH-1:0] in_data;
  logic                              in_ready;
  logic                              out_valid;
  logic [TB_HEIGHT*WORD_WIDTH-1:0]   out_data;
  logic                              out_ready;
  logic [COL_W-1:0]                  out_col_index;
  logic                              out_bank;
  logic                              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_col_index, out_bank, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_col_index, out_bank, out_last
  );
endinterface

// File: rtl/tb_column_reader.sv
// Ping-pong transpose reader: full memory rows fill one bank while the other bank
// is streamed out one column (one word per row) per cycle.
module tb_column_reader #(
  parameter int WORD_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int TB_HEIGHT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tb_column_reader_if.slave    bus
);
  localparam int COL_W = $clog2(FETCH_WIDTH);
  localparam int ROW_W = (TB_HEIGHT > 1) ? $clog2(TB_HEIGHT) : 1;

  logic [WORD_WIDTH-1:0] mem [2][TB_HEIGHT][FETCH_WIDTH];

  logic             wr_bank;
  logic [ROW_W-1:0] wr_row;
  logic             rd_bank;
  logic [COL_W-1:0] rd_col;
  logic [1:0]       full;
  logic [1:0]       full_next;

  logic wr_fire;
  logic rd_fire;
  logic wr_row_last;
  logic rd_col_last;

  // Writes only target a non-full bank and reads only a full one, so the two sides never collide.
  assign bus.in_ready  = ~full[wr_bank];
  assign bus.out_valid = full[rd_bank];

  assign wr_fire     = bus.in_valid & bus.in_ready;
  assign rd_fire     = bus.out_valid & bus.out_ready;
  assign wr_row_last = (wr_row == ROW_W'(TB_HEIGHT - 1));
  assign rd_col_last = (rd_col == COL_W'(FETCH_WIDTH - 1));

  assign bus.out_col_index = rd_col;
  assign bus.out_bank      = rd_bank;
  assign bus.out_last      = rd_col_last;

  generate
    for (genvar gi = 0; gi < TB_HEIGHT; gi++) begin : g_out_word
      assign bus.out_data[gi*WORD_WIDTH +: WORD_WIDTH] = mem[rd_bank][gi][rd_col];
    end
  endgenerate

  // A bank filling and the other bank draining on the same edge must both take effect.
  always_comb begin
    full_next = full;
    if (wr_fire && wr_row_last) full_next[wr_bank] = 1'b1;
    if (rd_fire && rd_col_last) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_col  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        if (wr_row_last) begin
          wr_bank <= ~wr_bank;
          wr_row  <= '0;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_col_last) begin
          rd_bank <= ~rd_bank;
          rd_col  <= '0;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < TB_HEIGHT; r++) begin
          for (int c = 0; c < FETCH_WIDTH; c++) begin
            mem[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire) begin
      for (int c = 0; c < FETCH_WIDTH; c++) begin
        mem[wr_bank][wr_row][c] <= bus.in_data[c*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end
endmodule
